// File: rtl/vid_fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter, its two requesters (TIA writer,
// scanout reader) and the single-port framebuffer RAM.
interface vid_fb_arbiter_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16
);
  logic                  wr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  wr, wr_addr, wr_data, rd_valid, rd_addr, mem_rdata,
    output rd_ready, rd_data, rd_data_valid, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester / RAM side
  modport master (
    output wr, wr_addr, wr_data, rd_valid, rd_addr, mem_rdata,
    input  rd_ready, rd_data, rd_data_valid, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vid_fb_arbiter.sv
// Framebuffer RAM arbiter: scanout reads win, TIA pixel writes are buffered in a
// FIFO and drained into free slots, with a read-run limiter to bound write stalls.
module vid_fb_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_RD_RUN = 4,
  parameter int MEM_LAT    = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  vid_fb_arbiter_if.slave               bus,
  output logic                          ovf_o,
  output logic [7:0]                    drop_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int RUN_W = $clog2(MAX_RD_RUN + 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  state_e                           state_q;
  logic [ADDR_WIDTH-1:0]            mem_addr_q;
  logic [DATA_WIDTH-1:0]            mem_wdata_q;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                 wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]                 count_q, count_d;
  logic [RUN_W-1:0]                 rd_run_q, rd_run_d;
  logic                             ovf_q;
  logic [7:0]                       drop_cnt_q;
  logic [MEM_LAT-1:0]               rd_pipe_q;
  logic [DATA_WIDTH-1:0]            rd_data_q;

  logic                  fifo_empty, fifo_full;
  logic                  grant_rd, grant_wr, push, drop;
  logic                  rd_issue, rd_tap;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == LVL_W'(FIFO_DEPTH));

  // rst_ni gates the grant so rd_ready_o stays low while reset is held
  assign grant_rd = rst_ni && bus.rd_valid &&
                    (fifo_empty || (rd_run_q < RUN_W'(MAX_RD_RUN)));
  assign grant_wr = rst_ni && !grant_rd && !fifo_empty;

  // A full FIFO still accepts a pixel when its head leaves in the same cycle
  assign push = bus.wr && (!fifo_full || grant_wr);
  assign drop = bus.wr && !push;

  assign {head_addr, head_data} = fifo_mem[rd_ptr_q];

  always_comb begin
    count_d  = count_q + LVL_W'(push) - LVL_W'(grant_wr);
    rd_run_d = rd_run_q;
    if (grant_rd) begin
      if (fifo_empty)
        rd_run_d = '0;
      else if (rd_run_q != RUN_W'(MAX_RD_RUN))
        rd_run_d = rd_run_q + RUN_W'(1);
    end else if (grant_wr) begin
      rd_run_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      fifo_mem[wr_ptr_q] <= {bus.wr_addr, bus.wr_data};
  end

  // Command FSM: state holds the RAM command issued for the current cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_run_q    <= '0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      count_q  <= count_d;
      rd_run_q <= rd_run_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_cnt_q != 8'hFF)
          drop_cnt_q <= drop_cnt_q + 8'd1;
      end
      if (grant_rd) begin
        state_q    <= RD;
        mem_addr_q <= bus.rd_addr;
      end else if (grant_wr) begin
        state_q     <= WR;
        mem_addr_q  <= head_addr;
        mem_wdata_q <= head_data;
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign rd_issue = (state_q == RD);

  // Capture RAM data in the cycle it is presented, MEM_LAT-1 cycles after issue
  generate
    if (MEM_LAT == 1) begin : g_tap_direct
      assign rd_tap = rd_issue;
    end else begin : g_tap_pipe
      assign rd_tap = rd_pipe_q[MEM_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pipe_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_pipe_q[0] <= rd_issue;
      for (int i = 1; i < MEM_LAT; i++)
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      if (rd_tap)
        rd_data_q <= bus.mem_rdata;
    end
  end

  assign bus.rd_ready      = grant_rd;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_pipe_q[MEM_LAT-1];
  assign bus.mem_en        = (state_q != IDLE);
  assign bus.mem_we        = (state_q == WR);
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign ovf_o             = ovf_q;
  assign drop_cnt_o        = drop_cnt_q;
  assign fifo_level_o      = count_q;

endmodule

// File: tb/tb_vid_fb_arbiter.sv
// Randomized bench for vid_fb_arbiter, checked against a queue-based model of
// the arbitration rules and a scoreboard of expected read returns.
module tb_vid_fb_arbiter;
  localparam int AW  = 17;
  localparam int DW  = 16;
  localparam int FD  = 16;
  localparam int MRR = 4;
  localparam int ML  = 1;
  localparam int LW  = $clog2(FD) + 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          ovf;
  logic [7:0]    drop_cnt;
  logic [LW-1:0] level;

  vid_fb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vid_fb_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .MAX_RD_RUN(MRR), .MEM_LAT(ML)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .ovf_o       (ovf),
    .drop_cnt_o  (drop_cnt),
    .fifo_level_o(level)
  );

  always #5 clk = ~clk;

  // RAM model: data presented in the command cycle is the address itself
  assign bus.mem_rdata = bus.mem_addr[15:0];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } px_t;
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rr_t;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            we_seen = 0;
  px_t           fq[$];
  rr_t           rq[$];
  int            run_m;
  bit            ovf_m;
  int            drop_m;
  bit            exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    fq.delete();
    rq.delete();
    run_m    = 0;
    ovf_m    = 0;
    drop_m   = 0;
    exp_en   = 0;
    exp_we   = 0;
    exp_addr = '0;
    exp_wd   = '0;
  endtask

  // Assert reset mid-cycle, check all outputs are cleared and stay cleared
  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    check_eq("rst_mem_en",   bus.mem_en,        0);
    check_eq("rst_mem_we",   bus.mem_we,        0);
    check_eq("rst_mem_addr", bus.mem_addr,      0);
    check_eq("rst_mem_wd",   bus.mem_wdata,     0);
    check_eq("rst_rd_data",  bus.rd_data,       0);
    check_eq("rst_ovf",      ovf,               0);
    check_eq("rst_drop",     drop_cnt,          0);
    for (int i = 0; i < 3; i++) begin
      bus.rd_valid = 1'b1;
      bus.wr       = 1'b1;
      #1;
      check_eq("rst_rd_ready", bus.rd_ready,      0);
      check_eq("rst_dvalid",   bus.rd_data_valid, 0);
      check_eq("rst_level",    level,             0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.wr       = 1'b0;
    bus.rd_valid = 1'b0;
    rst_n        = 1'b1;
  endtask

  // One clock cycle: check registered outputs, drive inputs, predict the grant
  task automatic step(input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit rv, input logic [AW-1:0] ra, output bit full_pop);
    bit  g_rd, g_wr;
    int  sz0;
    px_t px;
    full_pop = 0;
    check_eq("mem_en",     bus.mem_en,    exp_en);
    check_eq("mem_we",     bus.mem_we,    exp_we);
    check_eq("mem_addr",   bus.mem_addr,  exp_addr);
    check_eq("mem_wdata",  bus.mem_wdata, exp_wd);
    check_eq("fifo_level", level,         fq.size());
    check_eq("ovf",        ovf,           ovf_m);
    check_eq("drop_cnt",   drop_cnt,      drop_m);
    if (bus.mem_en)
      $display("cyc %0d mem %s addr=%05h wdata=%04h", cyc, bus.mem_we ? "WR" : "RD",
               bus.mem_addr, bus.mem_wdata);
    if (bus.mem_en && bus.mem_we)
      we_seen++;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      check_eq("rd_dvalid", bus.rd_data_valid, 1);
      check_eq("rd_data",   bus.rd_data,       rq[0].d);
      $display("cyc %0d rd return data=%04h", cyc, bus.rd_data);
      void'(rq.pop_front());
    end else begin
      check_eq("rd_dvalid", bus.rd_data_valid, 0);
    end

    bus.wr       = wr;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_valid = rv;
    bus.rd_addr  = ra;
    #1;

    sz0  = fq.size();
    g_rd = rv && (sz0 == 0 || run_m < MRR);
    g_wr = !g_rd && sz0 > 0;
    check_eq("rd_ready", bus.rd_ready, g_rd);

    if (g_rd) begin
      exp_en   = 1;
      exp_we   = 0;
      exp_addr = ra;
      rq.push_back('{due: cyc + 1 + ML, d: ra[15:0]});
      run_m = (sz0 == 0) ? 0 : ((run_m < MRR) ? run_m + 1 : MRR);
    end else if (g_wr) begin
      px       = fq.pop_front();
      exp_en   = 1;
      exp_we   = 1;
      exp_addr = px.a;
      exp_wd   = px.d;
      run_m    = 0;
    end else begin
      exp_en = 0;
      exp_we = 0;
    end

    if (wr) begin
      if (sz0 < FD || g_wr) begin
        fq.push_back('{a: wa, d: wd});
        full_pop = (sz0 == FD);
      end else begin
        ovf_m = 1;
        if (drop_m < 255)
          drop_m++;
      end
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bit fp;
    int w0;
    bus.wr = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 0; bus.rd_addr = '0;
    @(negedge clk);
    do_reset();

    // Writes only: five pixels, then drain
    for (int i = 0; i < 5; i++)
      step(1, AW'(32'h10 + i), DW'($urandom), 0, '0, fp);
    for (int i = 0; i < 6; i++)
      step(0, '0, '0, 0, '0, fp);
    check_eq("wonly_level", level, 0);

    // Read latency: address at N+1, data at N+2
    step(0, '0, '0, 1, AW'(32'h1234), fp);
    check_eq("lat_mem_en",   bus.mem_en,   1);
    check_eq("lat_mem_addr", bus.mem_addr, 32'h1234);
    step(0, '0, '0, 0, '0, fp);
    check_eq("lat_dvalid", bus.rd_data_valid, 1);
    check_eq("lat_data",   bus.rd_data,       32'h1234);
    step(0, '0, '0, 0, '0, fp);

    // Reset with a read in flight: its data must never be reported
    step(0, '0, '0, 1, AW'(32'h0abc), fp);
    do_reset();
    for (int i = 0; i < 3; i++)
      step(0, '0, '0, 0, '0, fp);

    // Starvation limit: three queued pixels under a continuous read stream
    for (int i = 0; i < 3; i++)
      step(1, AW'(32'h200 + i), DW'($urandom), 1, AW'($urandom), fp);
    w0 = we_seen;
    for (int i = 0; i < 20; i++)
      step(0, '0, '0, 1, AW'($urandom), fp);
    check_eq("starve_wr_cnt", we_seen - w0, 3);

    // Overflow under read pressure, including full-with-pop cycles
    for (int i = 0; i < 28; i++) begin
      step(1, AW'($urandom), DW'($urandom), 1, AW'($urandom), fp);
      if (fp)
        check_eq("full_pop_level", level, FD);
    end
    check_eq("ovf_set", ovf, 1);
    for (int i = 0; i < 25; i++)
      step(0, '0, '0, 0, '0, fp);
    check_eq("ovf_sticky",  ovf,   1);
    check_eq("drain_level", level, 0);

    // Random mix
    for (int i = 0; i < 300; i++)
      step(bit'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
           ($urandom_range(0, 9) < 6), AW'($urandom), fp);
    for (int i = 0; i < 25; i++)
      step(0, '0, '0, 0, '0, fp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vid_fb_arbiter.md
Name: vid_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM (320x240 RGB565, 17-bit address) between two requesters: the TIA pixel writer (vid_out/vid_addr/vid_wr) and the display scanout reader (HDMI/LCD pixel fetch).
- Scanout reads have priority. TIA writes are buffered in a small FIFO and drained into free memory slots.
- A run limiter guarantees that writes make progress during long read bursts.
- Sits between tia, the display controller and the framebuffer BRAM.

Parameters:
- ADDR_WIDTH, 17, framebuffer address width
- DATA_WIDTH, 16, pixel width (RGB565)
- FIFO_DEPTH, 16, write FIFO entries; power of 2, at least 4
- MAX_RD_RUN, 4, max consecutive read grants while the FIFO is non-empty
- MEM_LAT, 1, RAM read latency in cycles (1..3)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; asynchronous, active-low
- wr_i  in  1  pixel write strobe from tia (vid_wr); single-cycle pulse, no backpressure
- wr_addr_i  in  ADDR_WIDTH  pixel address (vid_addr)
- wr_data_i  in  DATA_WIDTH  pixel colour (vid_out)
- rd_valid_i  in  1  scanout read request
- rd_addr_i  in  ADDR_WIDTH  scanout read address
- rd_ready_o  out  1  read request accepted this cycle
- rd_data_o  out  DATA_WIDTH  read data
- rd_data_valid_o  out  1  rd_data_o valid (one pulse per accepted read)
- mem_en_o  out  1  RAM access enable
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  ADDR_WIDTH  RAM address
- mem_wdata_o  out  DATA_WIDTH  RAM write data
- mem_rdata_i  in  DATA_WIDTH  RAM read data
- ovf_o  out  1  sticky overflow flag; set when a write is dropped
- drop_cnt_o  out  8  count of dropped writes; saturates at 255
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_ni=0, async): FIFO empty, rd_run=0, state IDLE.
  - All outputs 0, including mem_*, rd_ready_o, rd_data_valid_o, ovf_o and drop_cnt_o.
  - The read-valid pipeline is cleared: data for in-flight reads is discarded and no rd_data_valid_o pulse occurs after reset.
- FIFO push:
  - Taken on wr_i=1 if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the write is dropped: ovf_o is set and stays set until reset, and drop_cnt_o increments (saturating).
  - Simultaneous push and pop on an empty FIFO is not a bypass: the pixel enters the FIFO and is written at the earliest one cycle later.
- Grant decision each cycle; FSM state holds the command issued last cycle (IDLE / RD / WR):
  - If rd_valid_i=1 and (FIFO empty or rd_run < MAX_RD_RUN): grant read. rd_ready_o=1 combinationally this cycle. rd_run increments (saturating at MAX_RD_RUN) when the FIFO is non-empty, and resets to 0 when the FIFO is empty. Next state RD.
  - Else if the FIFO is non-empty: grant write. Pop the head, set rd_run=0, next state WR.
  - Else: next state IDLE, rd_run unchanged.
- Memory command timing:
  - mem_* are registered; the grant made in cycle N drives mem_* in cycle N+1.
  - RD: mem_en_o=1, mem_we_o=0, mem_addr_o=rd_addr_i as sampled in cycle N.
  - WR: mem_en_o=1, mem_we_o=1, addr/data from the popped entry.
  - IDLE: mem_en_o=0, mem_we_o=0; addr/data hold their last values.
- Read return:
  - rd_data_valid_o pulses exactly MEM_LAT cycles after the mem_en_o&!mem_we_o cycle.
  - rd_data_o is registered from mem_rdata_i in that same cycle. Total request-to-data latency = 1+MEM_LAT cycles.
  - Reads return in order; back-to-back reads give back-to-back data.
- Ordering: writes retire in FIFO order. No read/write hazard checking; a scanout read may return a stale pixel, which is acceptable.
- Full throughput: one RAM access per cycle, no dead cycles between RD and WR.
- fifo_level_o is registered and reflects the post-push/pop count.

Test Plan:
- Reset mid-read: accept a read, drop rst_ni before data returns -> no rd_data_valid_o pulse; all outputs 0; FIFO level 0.
- Writes only: 5 wr_i pulses to addrs 0x00010..0x00014, rd_valid_i=0 -> 5 mem writes in order, first one 2 cycles after the first wr_i; fifo_level_o returns to 0.
- Read latency: MEM_LAT=1, RAM model returns addr[15:0]; rd_valid_i for addr 0x1234 -> mem_addr_o=0x1234 at N+1, rd_data_valid_o with 0x1234 at N+2.
- Starvation limit: FIFO holds 3 entries, rd_valid_i held high for 20 cycles, MAX_RD_RUN=4 -> grant pattern RRRRW RRRRW RRRRW, then all reads; every read returns data in order.
- Overflow: rd_valid_i high, MAX_RD_RUN=4, 20 consecutive wr_i pulses with FIFO_DEPTH=16 -> ovf_o=1 and drop_cnt_o equals pushes rejected at full (count checked against the model); ovf_o stays 1 after the FIFO drains.
- Full with simultaneous pop: FIFO full, a write grant and wr_i in the same cycle -> push accepted, no drop, level stays 16.
